// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 16-bit RISC core.
// It steps each instruction in the IR through fetch, decode, execute, memory
// and writeback. It drives the ALU opcode, the datapath mux selects, the
// register-file and PC write enables, and the memory request handshake.
// It counts retired instructions and halts on HALT or on an illegal opcode.
//
// Ports
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   instr        current IR contents, opcode = instr[15:12]
//   mem_ready    memory completes the request in the cycle it is high
//   alu_z        ALU zero flag, meaningful while alu_op = 4'b1111
//   alu_op       ALU operation select
//   alu_src_b    00 reg rt, 01 sext(instr[3:0]), 10 zext(instr[7:0])
//   ir_we        load IR from memory data
//   pc_we        PC write strobe
//   pc_src       00 PC+1, 01 PC+sext(instr[7:0]), 10 {PC[15:12], instr[11:0]}
//   reg_we       register-file write, dest = instr[11:8]
//   mem_to_reg   writeback source: 1 mem data, 0 ALU result
//   mem_req      memory request, held until mem_ready
//   mem_we       1 = store, qualifies mem_req
//   halted       sticky, set on entry to HALT
//   illegal      sticky, set when opcode 4'hE is decoded
//   retired      instructions completed since reset (wraps)
module control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             mem_ready,
  input  logic             alu_z,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_LUI  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_BEQ  = 4'hF;

  localparam logic [1:0] SRC_RT   = 2'b00;
  localparam logic [1:0] SRC_SEXT = 2'b01;
  localparam logic [1:0] SRC_ZEXT = 2'b10;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_ABS = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] opcode;
  logic [3:0] exec_alu_op;
  logic [1:0] exec_src;
  logic       retire;

  assign opcode = instr[15:12];

  // Operand fields are used by the datapath, not by the controller.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instr[11:0];

  // ALU setup for the current opcode, held from EXEC through MEM/WB.
  always_comb begin : exec_decode
    exec_alu_op = 4'h0;
    exec_src    = SRC_RT;
    if (opcode <= 4'h7) begin
      exec_alu_op = opcode;
    end else begin
      case (opcode)
        OP_LW, OP_SW, OP_ADDI: exec_src = SRC_SEXT;
        OP_LUI: begin
          exec_alu_op = 4'hC;
          exec_src    = SRC_ZEXT;
        end
        OP_BEQ: exec_alu_op = 4'hF;
        default: ;
      endcase
    end
  end

  // Next-state and control outputs.
  always_comb begin : fsm_comb
    state_next = state;
    alu_op     = 4'h0;
    alu_src_b  = SRC_RT;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_INC;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    retire     = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        if (opcode == OP_HALT || opcode == OP_ILL) state_next = S_HALT;
        else                                       state_next = S_EXEC;
      end

      S_EXEC: begin
        alu_op    = exec_alu_op;
        alu_src_b = exec_src;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM;
          OP_JMP: begin
            pc_we      = 1'b1;
            pc_src     = PC_ABS;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_BEQ: begin
            pc_we      = alu_z;
            pc_src     = PC_REL;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_WB;
        endcase
      end

      S_MEM: begin
        alu_op    = exec_alu_op;
        alu_src_b = exec_src;
        mem_req   = 1'b1;
        mem_we    = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end

      S_WB: begin
        alu_op     = exec_alu_op;
        alu_src_b  = exec_src;
        reg_we     = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_IDLE;
    endcase
  end

  // State, sticky flags and the retirement counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT)                   halted  <= 1'b1;
      if (state == S_DECODE && opcode == OP_ILL)  illegal <= 1'b1;
      if (retire)                                 retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: checks control_fsm against an instruction-level model.
// Each instruction is played as a sequence of phases with the expected
// control word for each cycle. A negedge process compares the DUT against
// that expectation on every checked cycle. Directed cases come first, then
// random opcodes, operands, memory wait counts, alu_z values and mem_ready
// noise.
module tb_control_fsm;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       mem_to_reg;
    logic       mem_req;
    logic       mem_we;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        mem_ready;
  logic        alu_z;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_b;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic        mem_to_reg;
  logic        mem_req;
  logic        mem_we;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  control_fsm #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .alu_z      (alu_z),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  ctl_t        exp_ctl;
  logic [15:0] exp_retired;
  logic        exp_halted;
  logic        exp_illegal;
  ctl_t        dut_ctl;

  assign dut_ctl = {alu_op, alu_src_b, ir_we, pc_we, pc_src, reg_we,
                    mem_to_reg, mem_req, mem_we};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctl_word", 32'(dut_ctl), 32'(exp_ctl));
      check("retired", 32'(retired), 32'(exp_retired));
      check("halted", 32'(halted), 32'(exp_halted));
      check("illegal", 32'(illegal), 32'(exp_illegal));
    end
  end

  // ALU setup each opcode uses while it executes.
  function automatic ctl_t alu_of(input logic [3:0] op);
    ctl_t c;
    c = '0;
    if (op < 4'h8) begin
      c.alu_op = op;
    end else if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
      c.alu_src_b = 2'b01;
    end else if (op == 4'hC) begin
      c.alu_op    = 4'hC;
      c.alu_src_b = 2'b10;
    end else if (op == 4'hF) begin
      c.alu_op = 4'hF;
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for one cycle, then leaves the DUT in its first FETCH cycle.
  task automatic do_reset();
    rst         = 1'b1;
    exp_ctl     = '0;
    exp_retired = '0;
    exp_halted  = 1'b0;
    exp_illegal = 1'b0;
    mem_ready   = 1'($urandom);
    step();
    rst = 1'b0;
    step();
  endtask

  // Plays one instruction, starting in FETCH.
  task automatic do_instr(input logic [15:0] w, input int fw, input int mw,
                          input logic z, input bit abort_mem);
    logic [3:0] op;
    ctl_t       base;
    op = w[15:12];
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; alu_z = 1'($urandom);
      exp_ctl = '0; exp_ctl.mem_req = 1'b1;
      step();
    end
    mem_ready = 1'b1; alu_z = 1'($urandom);
    exp_ctl = '0; exp_ctl.mem_req = 1'b1; exp_ctl.ir_we = 1'b1; exp_ctl.pc_we = 1'b1;
    step();
    instr = w;
    // decode
    mem_ready = 1'($urandom); alu_z = 1'($urandom); exp_ctl = '0;
    step();
    if (op == 4'hD || op == 4'hE) begin
      exp_halted = 1'b1;
      if (op == 4'hE) exp_illegal = 1'b1;
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'($urandom); alu_z = 1'($urandom); exp_ctl = '0;
        step();
      end
      return;
    end
    // execute
    base = alu_of(op);
    exp_ctl = base; mem_ready = 1'($urandom); alu_z = z;
    if (op == 4'hB) begin exp_ctl.pc_we = 1'b1; exp_ctl.pc_src = 2'b10; end
    if (op == 4'hF) begin exp_ctl.pc_we = z;    exp_ctl.pc_src = 2'b01; end
    step();
    if (op == 4'hB || op == 4'hF) begin exp_retired++; return; end
    // memory access
    if (op == 4'h8 || op == 4'h9) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0; alu_z = 1'($urandom);
        exp_ctl = base; exp_ctl.mem_req = 1'b1; exp_ctl.mem_we = (op == 4'h9);
        if (abort_mem) begin
          @(negedge clk);
          #2;
          rst = 1'b1;
          #1;
          check("mem_req_on_async_rst", 32'(mem_req), 32'd0);
          check("retired_on_async_rst", 32'(retired), 32'd0);
          do_reset();
          return;
        end
        step();
      end
      mem_ready = 1'b1; alu_z = 1'($urandom);
      exp_ctl = base; exp_ctl.mem_req = 1'b1; exp_ctl.mem_we = (op == 4'h9);
      step();
      if (op == 4'h9) begin exp_retired++; return; end
    end
    // writeback
    exp_ctl = base; exp_ctl.reg_we = 1'b1; exp_ctl.mem_to_reg = (op == 4'h8);
    mem_ready = 1'($urandom); alu_z = 1'($urandom);
    step();
    exp_retired++;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] w;
    int          fw;
    int          mw;
    bit          ab;
    rst = 1'b1; instr = 16'h0000; mem_ready = 1'b0; alu_z = 1'b0;
    exp_ctl = '0; exp_retired = '0; exp_halted = 1'b0; exp_illegal = 1'b0;
    #1;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_alu_op", 32'(alu_op), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    chk_en = 1'b1;
    do_reset();

    do_instr(16'h0123, 0, 0, 1'b0, 1'b0);      // ADD, zero-wait
    check("add_retired", 32'(retired), 32'd1);
    do_instr(16'h0456, 3, 0, 1'b0, 1'b0);      // three fetch wait cycles
    do_instr(16'h8125, 0, 2, 1'b0, 1'b0);      // LW, two memory wait cycles
    do_instr(16'hF012, 0, 0, 1'b1, 1'b0);      // BEQ taken
    do_instr(16'hF012, 0, 0, 1'b0, 1'b0);      // BEQ not taken
    check("beq_retired", 32'(retired), 32'd5);
    do_instr(16'hE000, 1, 0, 1'b0, 1'b0);      // illegal opcode
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_retired", 32'(retired), 32'd5);
    check("ill_no_mem_req", 32'(mem_req), 32'd0);
    do_reset();
    do_instr(16'h9321, 0, 2, 1'b0, 1'b1);      // SW interrupted by reset in MEM
    check("after_abort_retired", 32'(retired), 32'd0);
    do_instr(16'hB0FF, 0, 0, 1'b0, 1'b0);      // JMP
    check("jmp_retired", 32'(retired), 32'd1);

    for (int n = 0; n < 400; n++) begin
      op = 4'($urandom);
      w  = {op, 12'($urandom)};
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 2));
      ab = (op == 4'h9) && (mw > 0) && ($urandom_range(0, 7) == 0);
      do_instr(w, fw, mw, 1'($urandom), ab);
      if (op == 4'hD || op == 4'hE) do_reset();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
